cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Bridges the cache's full-line memory port to the 64-bit burst physical memory bus.
- Read miss: issues one burst read, collects BEATS beats, assembles them into one line and returns it.
- Writeback: splits one line into BEATS beats and issues them as one burst write.
- Sits between the cache controller/data arrays and the physical memory (or arbiter); one transaction outstanding at a time.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory data bus width; BEATS = LINE_WIDTH/BURST_WIDTH (4), which must be an integer ≥2.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-low reset (rst==0 at posedge resets).
- line_i  input  LINE_WIDTH  line to write back; sampled when a write is accepted.
- line_o  output  LINE_WIDTH  assembled read line.
- address_i  input  ADDR_WIDTH  line-aligned request address.
- read_i  input  1  cache read request (level).
- write_i  input  1  cache write request (level).
- resp_o  output  1  one-cycle completion pulse to the cache.
- burst_i  input  BURST_WIDTH  memory read beat data.
- burst_o  output  BURST_WIDTH  memory write beat data.
- address_o  output  ADDR_WIDTH  memory burst address.
- read_o  output  1  memory burst read request.
- write_o  output  1  memory burst write request.
- resp_i  input  1  memory beat strobe; one beat per cycle when high.

Behaviour:
- Reset values: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0, beat counter=0, state=IDLE.
- Reset applied mid-burst aborts the transaction. The next cycle shows read_o=write_o=0, and no resp_o is produced for the aborted request.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1 → latch address_i into address_o and line_i into the write buffer; counter=0; go to WRITE.
  - else read_i=1 → latch address_i; counter=0; go to READ.
  - Write has priority when both are high.
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1 and address_o held for the whole state.
  - Each cycle with resp_i=1: burst_i is stored into line_o[counter*BURST_WIDTH +: BURST_WIDTH], then counter increments.
  - Beats may arrive non-consecutively; cycles with resp_i=0 hold state.
  - On the beat with counter==BEATS-1, go to DONE. read_o is 0 from the next cycle.
- WRITE:
  - write_o=1; burst_o = buffer[counter*BURST_WIDTH +: BURST_WIDTH], driven combinationally from the counter. Beat 0 is valid in the first WRITE cycle.
  - Each cycle with resp_i=1 advances the counter.
  - On the beat with counter==BEATS-1, go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0.
  - For a read, line_o is complete and valid here.
  - Next state is IDLE unconditionally.
- Latency:
  - Request seen at cycle 0 → read_o/write_o high at cycle 1.
  - With back-to-back resp_i starting at cycle 1, beats land on cycles 1–4 and resp_o is high at cycle 5.
- Request hold:
  - The cache holds read_i/write_i until it sees resp_o.
  - A request still high in the DONE cycle is not re-accepted. A new request is accepted only in IDLE, so the earliest new acceptance is the cycle after DONE.
  - Requests arriving while busy are ignored.
- Output stability:
  - line_o holds its last assembled value until the next read overwrites it, beat by beat.
  - address_o holds its last value in IDLE.
- Counter:
  - Width is $clog2(BEATS).
  - It wraps to 0 after the last beat and is also cleared on every acceptance.
- Extra resp_i: if resp_i arrives in DONE or IDLE, it is ignored and no data is captured.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: read_i=1, address_i=0x0000_1040; beats 0x1111..., 0x2222..., 0x3333..., 0x4444... with resp_i high for 4 consecutive cycles.
  - Required: read_o=1 on cycles 1–4 with address_o=0x1040; resp_o=1 only on cycle 5; line_o = {0x4444..,0x3333..,0x2222..,0x1111..}.
- Write with gaps:
  - Stimulus: write_i=1, line_i = {D3,D2,D1,D0}; resp_i pattern 1,0,1,0,0,1,1.
  - Required: burst_o shows D0, D1, D2, D3 in order, each held until its resp_i; write_o drops after the 4th beat; resp_o pulses once.
- Simultaneous requests:
  - Stimulus: read_i=write_i=1.
  - Required: a write burst is issued; read_o stays 0 for the whole transaction.
- Reset mid-read:
  - Stimulus: rst=0 after 2 beats, then a fresh read.
  - Required: read_o=0 and resp_o=0 the cycle after reset; line_o=0; the new read collects 4 fresh beats and the counter starts at 0.
- Back-to-back transactions:
  - Stimulus: read_i held through DONE, then deasserted; a new write_i is raised the cycle after DONE.
  - Required: no duplicate read is issued; the write is accepted from IDLE; resp_o pulses exactly twice in total.
- Spurious resp_i:
  - Stimulus: resp_i=1 while in IDLE.
  - Required: no state change; resp_o=0; line_o unchanged.

Source files
------------

// File: rtl/cacheline_adaptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Bridges a cache's full-line memory port to a narrow burst
//                memory bus. A read miss becomes one burst read whose beats
//                are assembled into a line. A writeback line is split into
//                beats and sent as one burst write. Only one transaction is
//                outstanding at a time.
//
//  Ports (cache side)
//    clk        : clock, all state updates on the rising edge
//    rst        : synchronous active-low reset
//    line_i     : line to write back, captured when a write is accepted
//    line_o     : assembled read line, valid in the DONE cycle of a read
//    address_i  : line-aligned request address
//    read_i     : read request (level, held until resp_o)
//    write_i    : write request (level, held until resp_o)
//    resp_o     : one-cycle completion pulse
//
//  Ports (memory side)
//    burst_i    : read beat data
//    burst_o    : write beat data for the current beat
//    address_o  : burst address
//    read_o     : burst read request
//    write_o    : burst write request
//    resp_i     : beat strobe, one beat per cycle while high
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,

    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;
    logic [CNT_W-1:0]                    r_cnt;
    logic [CNT_W-1:0]                    w_cnt_inc;
    logic                                w_last_beat;
    logic [ADDR_WIDTH-1:0]               r_addr;
    // Lines are held as arrays of beats so the beat counter indexes them
    // directly; the packed layout puts beat 0 in the least significant bits.
    logic [BEATS-1:0][BURST_WIDTH-1:0]   r_line;
    logic [BEATS-1:0][BURST_WIDTH-1:0]   r_wbuf;

    assign w_last_beat = (r_cnt == C_LAST_BEAT);
    // Explicit wrap keeps the counter correct for non-power-of-two BEATS.
    assign w_cnt_inc   = w_last_beat ? '0 : r_cnt + 1'b1;

    assign line_o    = r_line;
    assign address_o = r_addr;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and bus outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        burst_o      = '0;

        case (r_state)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (write_i) begin
                    w_state_next = WRITE;
                end else if (read_i) begin
                    w_state_next = READ;
                end
            end

            READ: begin
                read_o = 1'b1;
                if (resp_i && w_last_beat) begin
                    w_state_next = DONE;
                end
            end

            WRITE: begin
                write_o = 1'b1;
                // Current beat is presented straight from the counter so beat 0
                // is on the bus in the first WRITE cycle.
                burst_o = r_wbuf[r_cnt];
                if (resp_i && w_last_beat) begin
                    w_state_next = DONE;
                end
            end

            DONE: begin
                // The cache still holds its request here; returning to IDLE
                // unconditionally prevents that stale request being re-accepted.
                resp_o       = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: address latch, write buffer, read assembly, beat counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_line <= '0;
            r_wbuf <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_addr <= address_i;
                        r_wbuf <= line_i;
                        r_cnt  <= '0;
                    end else if (read_i) begin
                        r_addr <= address_i;
                        r_cnt  <= '0;
                    end
                end

                READ: begin
                    if (resp_i) begin
                        r_line[r_cnt] <= burst_i;
                        r_cnt         <= w_cnt_inc;
                    end
                end

                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    // DONE: beats arriving here are not captured.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
